// File: rtl/array_sum_engine_pkg.sv
// Shared types and default sizing for the sum-of-array read engine.
package array_sum_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 9;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/array_sum_engine_if.sv
// Block RAM read port: the engine drives enable/address, the RAM returns data.
interface array_sum_engine_if
  import array_sum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_val;

  modport master (output read_en, output read_addr, input read_val);
  modport slave  (input read_en, input read_addr, output read_val);

endinterface

// File: rtl/array_sum_engine_lat_valid_pipe.sv
// Valid tracker for a fixed-latency read port: bit i is high when the read
// issued i+1 cycles ago is in flight; the top bit marks data valid now.
module lat_valid_pipe
  import array_sum_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             vld_in,
  output logic [DEPTH-1:0] vld_pipe
);

  // Shift the issue strobe down the pipe; clearing drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_in;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

endmodule

// File: rtl/array_sum_engine.sv
// Streams len words from the block RAM starting at byte address base and
// accumulates them into a DATA_W-bit sum, pulsing done when final.
// Optional: define ARRAY_SUM_OVF_EN to add a sticky carry-out flag 'ovf'.
module array_sum_engine
  import array_sum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base,
  input  logic [LEN_W-1:0]   len,
  array_sum_engine_if.master rd,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  sum
`ifdef ARRAY_SUM_OVF_EN
  ,
  output logic               ovf
`endif
);

  // Every stage except the last; when these are clear the final word is
  // landing this cycle, so DONE can follow directly.
  localparam logic [RD_LAT-1:0] LOW_MASK = {RD_LAT{1'b1}} >> 1;

  state_t             state;
  logic               read_en_q;
  logic [ADDR_W-1:0]  read_addr_q;
  logic [LEN_W-1:0]   left;
  logic [RD_LAT-1:0]  vld_pipe;
  logic               acc_en;

  assign rd.read_en   = read_en_q;
  assign rd.read_addr = read_addr_q;
  assign acc_en       = vld_pipe[RD_LAT-1];

`ifdef ARRAY_SUM_OVF_EN
  logic [DATA_W:0] acc_full;
  assign acc_full = {1'b0, sum} + {1'b0, rd.read_val};
`else
  logic [DATA_W-1:0] acc_nxt;
  assign acc_nxt = sum + rd.read_val;
`endif

  lat_valid_pipe #(.DEPTH(RD_LAT)) u_vld (
    .clk      (clk),
    .clr_n    (rst_n),
    .vld_in   (read_en_q),
    .vld_pipe (vld_pipe)
  );

  // Sequencer FSM with registered RAM controls plus the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      left        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
`ifdef ARRAY_SUM_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      // Pipe is always empty in IDLE, so this never collides with the clear.
      if (acc_en) begin
`ifdef ARRAY_SUM_OVF_EN
        sum <= acc_full[DATA_W-1:0];
        if (acc_full[DATA_W]) ovf <= 1'b1;
`else
        sum <= acc_nxt;
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            sum  <= '0;
            busy <= 1'b1;
`ifdef ARRAY_SUM_OVF_EN
            ovf  <= 1'b0;
`endif
            if (len != '0) begin
              state       <= ISSUE;
              read_en_q   <= 1'b1;
              read_addr_q <= base;
              left        <= len - 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (left == '0) begin
            read_en_q <= 1'b0;
            state     <= DRAIN;
          end else begin
            // Byte address wraps naturally at 2^ADDR_W.
            read_addr_q <= read_addr_q + ADDR_W'(4);
            left        <= left - 1'b1;
          end
        end
        DRAIN: begin
          if ((vld_pipe & LOW_MASK) == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/array_sum_engine.md
# array_sum_engine

Read-side sequencer and accumulator for the sum-of-array datapath. On `start` it streams word reads from the dual-port block RAM: `read_en`/`read_addr` are driven straight into the RAM read port and each returned `read_val` is added into a 32-bit running sum. It tracks the RAM's fixed two-cycle read latency with a valid shift register. It reports the result with a one-cycle `done` pulse. The RAM's write port is owned by the upstream loader and is not touched here.

## Interface
- `ADDR_W`, 10: RAM read address width; byte address, RAM indexes by `addr >> 2`.
- `DATA_W`, 32: word and sum width.
- `LEN_W`, 9: length width; 0..256 words.
- `RD_LAT`, 2: RAM read latency, `read_en` cycle to valid `read_val` cycle.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a summation; sampled only in IDLE.
- `base` in ADDR_W: byte address of the first word; multiple of 4.
- `len` in LEN_W: word count; sampled with `start`.
- `read_en` out 1: RAM read enable.
- `read_addr` out ADDR_W: RAM read byte address.
- `read_val` in DATA_W: RAM read data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `sum` is final.
- `sum` out DATA_W: accumulator.

## Operation
- FSM states:
  - IDLE: `start`=1 and `len`≠0 → ISSUE; `start`=1 and `len`=0 → DONE; `start`=0 → stay.
  - ISSUE: one read per cycle. `read_addr` = `base` + 4·i for i = 0..len-1. After the last issue → DRAIN.
  - DRAIN: wait until the valid shift register is empty → DONE.
  - DONE: assert `done` for one cycle → IDLE.
- Accepting `start` clears `sum` to 0 and latches `base`/`len`.
- Valid shift register: RD_LAT bits. Stage 0 is loaded with `read_en`. When the last stage is high, `sum` <= `sum` + `read_val`.
- Arithmetic is modulo 2^DATA_W; carry out is dropped.
- Address increments by 4 and wraps modulo 2^ADDR_W.
- `start` outside IDLE is ignored and not queued.
- `read_val` is ignored whenever the last valid stage is low.
- `sum` holds its value after DONE until the next accepted `start`.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE;
  - `read_en`=0, `read_addr`=0, `busy`=0, `done`=0, `sum`=0;
  - valid shift register cleared.
- Reset mid-operation discards in-flight reads; their later `read_val` is never accumulated.
- `start` is sampled at edge of cycle 0:
  - `read_en` is high in cycles 1..len;
  - the word read in cycle k is accumulated at the end of cycle k+2;
  - DRAIN covers cycles len+1..len+2;
  - `done` is high in cycle len+3.
- `len`=0: `done` is high in cycle 1; no reads are issued; `sum`=0.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- The earliest next `start` is accepted in the cycle after `done`.
- `read_en` and `read_addr` are registered outputs.

## Configuration
- `ARRAY_SUM_OVF_EN` defined:
  - adds output port `ovf` (1 bit);
  - `ovf` is set when any accumulation produces a carry out of bit DATA_W-1;
  - it is sticky until the next accepted `start` or reset;
  - it is valid with `done`;
  - its reset value is 0.
- `ARRAY_SUM_OVF_EN` undefined: no `ovf` port and no carry logic; wrap-around is silent.

## Structure
- Package `array_sum_pkg`: state enum (IDLE, ISSUE, DRAIN, DONE) and default constants for ADDR_W, DATA_W, LEN_W, RD_LAT.
- Sub-module `lat_valid_pipe`: a parameterised RD_LAT-deep valid shift register with synchronous active-low clear. Reusable by any consumer of the RAM read port.

## Test plan
- `base`=0, `len`=4, RAM words 0..3 = 1,2,3,4:
  - `read_addr` = 0,4,8,12 in cycles 1..4;
  - `done` in cycle 7 with `sum`=10.
- `len`=0 → `done` in cycle 1, `sum`=0, `read_en` never asserted.
- `base`=1020 (byte address of word 255), `len`=2:
  - `read_addr` = 1020 then 0 (wrap);
  - `sum` = word255 + word0.
- `len`=2, words = 0xFFFFFFFF and 0x00000002:
  - `sum`=0x00000001;
  - `ovf`=1 with `ARRAY_SUM_OVF_EN` defined.
- `start` pulsed again during ISSUE → ignored; the single `done` carries the first run's sum.
- `rst_n` low in cycle 2 of a `len`=8 run:
  - all outputs are 0 on the next cycle;
  - no accumulation from the stale reads;
  - a new run with `len`=1 on word value 5 gives `sum`=5.
